// File: rtl/mips_timer_if.sv
// Data-memory side bus between the address-decode bridge and the timer.
// The bridge drives the master side, the timer answers on the slave side.
interface mips_timer_if;
  logic        sel;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output sel,
    output we,
    output byteen,
    output addr,
    output wdata,
    input  rdata,
    input  irq
  );

  modport slave (
    input  sel,
    input  we,
    input  byteen,
    input  addr,
    input  wdata,
    output rdata,
    output irq
  );
endinterface

// File: rtl/mips_timer.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes.
// CTRL/PRESET stores restart the sequencer from IDLE and clear the flag.
module mips_timer #(
  parameter int BASE_OFFSET_BITS = 4
) (
  input  logic clk,
  input  logic reset,
  mips_timer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_e;

  localparam logic [1:0] MODE_AUTO = 2'd1;

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;

  logic [1:0]  reg_sel;
  logic        wr_en;
  logic        wr_ctrl;
  logic        wr_pre;
  logic        rd_ctrl;
  logic        rd_pre;
  logic        rd_cnt;
  logic [31:0] rdata;
  logic        unused_addr;

  assign reg_sel = bus.addr[BASE_OFFSET_BITS-1 -: 2];
  assign unused_addr = ^bus.addr;

  // Only full-word stores are honoured; partial stores are dropped.
  assign wr_en   = bus.sel & bus.we
                 & (bus.byteen == 4'b1111);
  assign wr_ctrl = wr_en & (reg_sel == 2'd0);
  assign wr_pre  = wr_en & (reg_sel == 2'd1);

  assign rd_ctrl = (reg_sel == 2'd0);
  assign rd_pre  = (reg_sel == 2'd1);
  assign rd_cnt  = (reg_sel == 2'd2);

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;
    if (wr_ctrl || wr_pre) begin
      // Bus store overrides whatever the sequencer would do this edge.
      if (wr_ctrl) begin
        en_d   = bus.wdata[0];
        mode_d = bus.wdata[2:1];
        im_d   = bus.wdata[3];
      end
      if (wr_pre) begin
        preset_d = bus.wdata;
      end
      flag_d  = 1'b0;
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (en_q) begin
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          count_d = preset_q;
          state_d = S_CNT;
        end
        S_CNT: begin
          if (!en_q) begin
            state_d = S_IDLE;
          end else if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            count_d = 32'd0;
            flag_d  = 1'b1;
            state_d = S_INT;
          end
        end
        S_INT: begin
          state_d = S_IDLE;
          if (mode_q == MODE_AUTO) begin
            flag_d = 1'b0;
          end else begin
            en_d = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      en_q     <= 1'b0;
      mode_q   <= 2'd0;
      im_q     <= 1'b0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    unique case (1'b1)
      rd_ctrl: rdata = {28'd0, im_q, mode_q, en_q};
      rd_pre:  rdata = preset_q;
      rd_cnt:  rdata = count_q;
      default: rdata = 32'd0;
    endcase
  end

  assign bus.rdata = rdata;
  assign bus.irq   = im_q & flag_q;

endmodule

// File: tb/tb_mips_timer.sv
// Bench for mips_timer: vector table, directed corner sequences,
// then random bus traffic against an elapsed-cycle reference model.
module tb_mips_timer;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mips_timer_if bus();

  mips_timer #(.BASE_OFFSET_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        s;
    logic        w;
    logic [3:0]  be;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[15];

  // Reference model: tracks the edge at which the timer was (re)armed and
  // derives COUNT / flag from elapsed edges.
  bit          m_en;
  bit [1:0]    m_mode;
  bit          m_im;
  bit [31:0]   m_preset;
  bit [31:0]   m_count;
  bit          m_flag;
  bit          m_run;
  longint      m_epoch;
  longint      m_cyc;

  function automatic void m_reset();
    m_en = 0; m_mode = 0; m_im = 0;
    m_preset = 0; m_count = 0; m_flag = 0;
    m_run = 0; m_epoch = 0; m_cyc = 0;
  endfunction

  function automatic void m_step(input logic s, input logic w,
                                 input logic [3:0] be,
                                 input logic [31:0] a,
                                 input logic [31:0] d);
    longint k;
    longint n;
    logic [1:0] r;
    m_cyc++;
    r = a[3:2];
    if (s && w && be == 4'hF && (r == 2'd0 || r == 2'd1)) begin
      if (r == 2'd0) begin
        m_en = d[0]; m_mode = d[2:1]; m_im = d[3];
      end else begin
        m_preset = d;
      end
      m_flag  = 0;
      m_run   = m_en;
      m_epoch = m_cyc;
    end else if (m_run) begin
      k = m_cyc - m_epoch;
      n = (m_preset == 0) ? 1 : longint'(m_preset);
      if (k >= 2 && k <= n + 2) m_count = 32'(n - (k - 2));
      if (k == n + 2) m_flag = 1;
      if (k == n + 3) begin
        if (m_mode == 2'd1) begin
          m_flag  = 0;
          m_epoch = m_cyc;
        end else begin
          m_en  = 0;
          m_run = 0;
        end
      end
    end
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [1:0] r;
    r = a[3:2];
    case (r)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input logic s, input logic w, input logic [3:0] be,
                      input logic [31:0] a, input logic [31:0] d);
    bus.sel = s; bus.we = w; bus.byteen = be;
    bus.addr = a; bus.wdata = d;
    @(posedge clk);
    #1;
    bus.sel = 1'b0; bus.we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    tick(1'b1, 1'b1, 4'hF, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 4'h0, bus.addr, 32'd0);
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] v);
    bus.addr = a;
    #1;
    v = bus.rdata;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.sel = 0; bus.we = 0; bus.byteen = 0;
    bus.addr = 0; bus.wdata = 0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] v;
  logic        prev;
  logic        any;
  int          highs;
  int          rises[$];

  initial begin
    checks = 0;
    failures = 0;
    tbl[0]  = '{1'b1, 1'b1, 4'hF, 32'h4, 32'd5,      32'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 4'hF, 32'h0, 32'h9,      32'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'h0, 32'h8, 32'd0,      32'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'h0, 32'h8, 32'd0,      32'd0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'h0, 32'h8, 32'd0,      32'd5, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'h0, 32'h8, 32'd0,      32'd4, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4'h0, 32'h8, 32'd0,      32'd3, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'h0, 32'h8, 32'd0,      32'd2, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 4'h0, 32'h8, 32'd0,      32'd1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'h0, 32'h8, 32'd0,      32'd0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 4'h0, 32'h0, 32'd0,      32'h8, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 4'hF, 32'h0, 32'h8,      32'h8, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 4'h0, 32'h0, 32'd0,      32'h8, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 4'h3, 32'h4, 32'h1234,   32'd5, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 4'h0, 32'h4, 32'd0,      32'd5, 1'b0};

    do_reset();

    // One-shot sequence and partial-store rejection
    for (int i = 0; i < 15; i++) begin
      bus.sel = tbl[i].s; bus.we = tbl[i].w; bus.byteen = tbl[i].be;
      bus.addr = tbl[i].a; bus.wdata = tbl[i].d;
      #1;
      chk($sformatf("vec%0d_rdata", i), bus.rdata, tbl[i].exp_rd);
      chk($sformatf("vec%0d_irq", i), {31'd0, bus.irq},
          {31'd0, tbl[i].exp_irq});
      @(posedge clk);
      #1;
      bus.sel = 1'b0; bus.we = 1'b0;
    end

    // Asynchronous reset while counting
    wr(32'h4, 32'd5);
    wr(32'h0, 32'h1);
    idle(3);
    peek(32'h8, v); chk("rst_pre_count", v, 32'd4);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      peek(32'(i * 4), v);
      chk($sformatf("rst_off%0d", i), v, 32'd0);
    end
    chk("rst_irq", {31'd0, bus.irq}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    any = 1'b0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      peek(32'h8, v);
      if (v != 0 || bus.irq) any = 1'b1;
    end
    chk("rst_idle20", {31'd0, any}, 32'd0);

    // Auto-reload pulse spacing
    wr(32'h4, 32'd3);
    wr(32'h0, 32'hB);
    prev = 1'b0; highs = 0;
    for (int c = 1; c <= 40; c++) begin
      idle(1);
      if (bus.irq) highs++;
      if (bus.irq && !prev) rises.push_back(c);
      prev = bus.irq;
    end
    chk("auto_nrises", (rises.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
    if (rises.size() >= 5) begin
      chk("auto_first", rises[0], 32'd5);
      for (int i = 1; i < 5; i++)
        chk($sformatf("auto_period%0d", i), rises[i] - rises[i-1], 32'd6);
    end
    chk("auto_width", highs, rises.size());
    wr(32'h0, 32'h0);

    // Masked interrupt
    wr(32'h4, 32'd2);
    wr(32'h0, 32'h1);
    any = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      if (bus.irq) any = 1'b1;
    end
    chk("mask_irq", {31'd0, any}, 32'd0);
    peek(32'h8, v); chk("mask_count", v, 32'd0);
    peek(32'h0, v); chk("mask_ctrl", v, 32'd0);

    // CTRL store on the edge COUNT reaches zero
    wr(32'h4, 32'd3);
    wr(32'h0, 32'h9);
    idle(4);
    peek(32'h8, v); chk("prio_pre", v, 32'd1);
    wr(32'h0, 32'h8);
    chk("prio_irq", {31'd0, bus.irq}, 32'd0);
    idle(3);
    chk("prio_irq_late", {31'd0, bus.irq}, 32'd0);
    peek(32'h8, v); chk("prio_count", v, 32'd1);

    // Pause and resume
    wr(32'h4, 32'd10);
    wr(32'h0, 32'h1);
    idle(5);
    peek(32'h8, v); chk("pause_at7", v, 32'd7);
    wr(32'h0, 32'h0);
    idle(4);
    peek(32'h8, v); chk("pause_hold", v, 32'd7);
    wr(32'h0, 32'h1);
    idle(1);
    peek(32'h8, v); chk("resume_load", v, 32'd7);
    idle(1);
    peek(32'h8, v); chk("resume_reload", v, 32'd10);
    wr(32'h0, 32'h0);

    // PRESET 0 behaves as PRESET 1
    wr(32'h4, 32'd0);
    wr(32'h0, 32'h9);
    idle(2);
    chk("zero_irq_e2", {31'd0, bus.irq}, 32'd0);
    idle(1);
    chk("zero_irq_e3", {31'd0, bus.irq}, 32'd1);
    wr(32'h4, 32'd1);
    idle(2);
    chk("one_irq_e2", {31'd0, bus.irq}, 32'd0);
    peek(32'h8, v); chk("one_count_e2", v, 32'd1);
    idle(1);
    chk("one_irq_e3", {31'd0, bus.irq}, 32'd1);

    // Random bus traffic against the model
    do_reset();
    m_reset();
    for (int i = 0; i < 3000; i++) begin
      logic s, w;
      logic [3:0] be;
      logic [31:0] a, d;
      s  = ($urandom_range(0, 7) == 0);
      w  = ($urandom_range(0, 3) != 0);
      be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      a  = $urandom;
      d  = 32'($urandom_range(0, 15));
      if (a[3:2] == 2'd0) d = d | ($urandom & 32'hFFFF_FFF0);
      bus.sel = s; bus.we = w; bus.byteen = be;
      bus.addr = a; bus.wdata = d;
      #1;
      chk("rand_rdata", bus.rdata, m_read(a));
      chk("rand_irq", {31'd0, bus.irq}, {31'd0, m_im & m_flag});
      @(posedge clk);
      m_step(s, w, be, a, d);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_timer.md
# mips_timer

Memory-mapped countdown timer that sits directly downstream of the CPU data-memory port, behind the address-decode bridge. It consumes the same store traffic the core drives on `m_data_addr` / `m_data_wdata` / `m_data_byteen` and returns read data into the `m_data_rdata` path. It provides one-shot and auto-reload counting, and produces a level interrupt request for the future exception stage.

## Interface
- `BASE_OFFSET_BITS`, default 4: number of low address bits decoded inside the block. Only `addr[3:2]` selects a register.
- `clk` input 1: single system clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low. `reset == 0` clears all state immediately.
- `sel` input 1: bridge has decoded an access to this device this cycle.
- `we` input 1: store qualifier from the M-stage memory write.
- `byteen` input 4: store byte enables. Only `4'b1111` performs a write.
- `addr` input 32: M-stage data address. Bits [3:2] are used.
- `wdata` input 32: store data.
- `rdata` output 32: combinational read data for `addr[3:2]`.
- `irq` output 1: interrupt request, equal to `ctrl_im & irq_flag`.

## Operation
- **Registers**, selected by `addr[3:2]`:
  - 0 = CTRL: bit0 EN, bits[2:1] MODE, bit3 IM. Reads return bits[31:4] = 0.
  - 1 = PRESET: 32-bit, read/write.
  - 2 = COUNT: read-only.
  - 3 = reserved: reads 0, writes ignored.
- **Write condition**: `sel & we & (byteen == 4'b1111)`. Any other `byteen` value is ignored in full; there is no partial merge.
- **CTRL write**: loads bits[3:0], clears `irq_flag`, forces the state machine to IDLE. COUNT is held.
- **PRESET write**: loads PRESET, clears `irq_flag`, forces IDLE.
- **COUNT and reserved writes**: no effect.
- **MODE values**: 0 = one-shot, 1 = auto-reload. MODE 2 and 3 behave as 0.
- **State machine**, states IDLE, LOAD, CNT, INT:
  - IDLE: if EN, go to LOAD; otherwise stay.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If EN == 0, go to IDLE with COUNT frozen.
    - Else if COUNT > 1, COUNT <= COUNT − 1.
    - Else COUNT <= 0, `irq_flag` <= 1, go to INT.
  - INT, one-shot: EN <= 0, go to IDLE. `irq_flag` stays set until the next CTRL or PRESET write.
  - INT, auto-reload: go to IDLE and clear `irq_flag`. EN stays 1, so the timer reloads.
- **Priority**: a qualifying bus write in the same cycle as an FSM update wins.
  - The written field takes the bus value.
  - The state becomes IDLE.
  - The flag clears, even if the FSM was entering INT on that edge.
- **PRESET = 0**: behaves as PRESET = 1 (one CNT cycle, then INT).
- **Arithmetic**: 32-bit unsigned. COUNT never wraps below 0.
- **Reset (reset == 0)**, asynchronous:
  - CTRL = 0, PRESET = 0, COUNT = 0, `irq_flag` = 0, state = IDLE.
  - `irq` = 0.
  - `rdata` reflects the cleared registers.
  - Reset mid-count aborts immediately; there is no pending interrupt afterwards.

## Timing
- `rdata` is combinational from `addr` and the current registers; there are no read side effects.
- Write at edge E0 enabling the timer with PRESET = N (N ≥ 1):
  - E1: LOAD.
  - E2: COUNT = N, state CNT.
  - E2+N: COUNT = 0, state INT, `irq` high if IM.
  - First-interrupt latency is N + 2 cycles.
- **One-shot**: `irq` stays high from E2+N until a CTRL or PRESET write. EN reads 0 from E3+N.
- **Auto-reload**: `irq` is high for exactly one cycle. Period is N + 3 cycles (INT, IDLE, LOAD, plus N CNT edges).
- **Clearing EN mid-count**: the CTRL write edge sets IDLE directly; COUNT holds its value.
- **Re-enabling**: always restarts from PRESET via LOAD.

## Test plan
- **Reset**: hold `reset` = 0 with EN = 1 and PRESET = 5 previously written, release it, read all 4 offsets -> all read 0, `irq` = 0, COUNT stays 0 for 20 cycles.
- **One-shot**: write PRESET = 5, then CTRL = 0x9 (EN, IM, mode 0) -> COUNT reads 5,4,3,2,1,0 on E2..E7; `irq` rises at E7 and stays high; CTRL reads 0x8 from E8; a write of CTRL = 0x8 drops `irq` the next cycle.
- **Auto-reload**: PRESET = 3, CTRL = 0xB -> `irq` is a one-cycle pulse, with rising edges exactly 6 cycles apart over 4 periods.
- **Masked interrupt**: PRESET = 2, CTRL = 0x1 -> state reaches INT, `irq` stays 0 throughout; COUNT reads 0 afterwards.
- **Byte-enable and priority**:
  - A PRESET write with `byteen` = 4'b0011 leaves PRESET unchanged.
  - A CTRL write landing on the same edge COUNT hits 0 leaves `irq` = 0 and the state in IDLE.
- **Pause / zero preset**:
  - Clearing EN while COUNT = 7 freezes COUNT at 7.
  - Re-enabling reloads PRESET.
  - PRESET = 0 yields `irq` 2 cycles after LOAD, the same as PRESET = 1.
